// File: rtl/rf_alu_core.sv
// Register-file + ALU execution core: valid/ready command port, registered execute stage with forwarding.
// Define RF_ALU_MUL_EN to include the iterative shift-add multiplier (funct 1100) and its MUL state.
module rf_alu_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int SH_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              RegWrite,
  input  logic [SH_W-1:0]   shamt,
  input  logic [3:0]        funct,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef RF_ALU_MUL_EN
  localparam int CNT_W = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_MUL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1} state_t;
`endif

  state_t state_q, state_d;

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rd_data1_q, rd_data2_q, result_q;
  logic [ADDR_W-1:0] wr_q;
  logic              we_q;

`ifdef RF_ALU_MUL_EN
  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q;
`endif

  logic              accept, wb_en, is_mul;
  logic [DATA_W-1:0] op1, op2, alu_res;

  function automatic logic [DATA_W-1:0] alu_f(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] im,
    input logic [3:0]        f,
    input logic [SH_W-1:0]   sh
  );
    logic [DATA_W-1:0] r;
    r = '0;
    case (f)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = ~(a | b);
      4'b0110: r = b << sh;
      4'b0111: r = b >> sh;
      4'b1000: r = DATA_W'($signed(b) >>> sh);
      4'b1001: r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1010: r = {{(DATA_W-1){1'b0}}, (a < b)};
      4'b1011: r = im;
      default: r = '0;  // MUL result arrives later from the multiplier
    endcase
    return r;
  endfunction

  // The EXEC-stage result lands in the RF on the same edge a new command captures
  // operands, so matching sources take result_q instead of the stale array entry.
  assign wb_en = (state_q == S_EXEC) && we_q && (wr_q != '0);

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (rd_addr1 != '0) op1 = (wb_en && rd_addr1 == wr_q) ? result_q : rf_q[rd_addr1];
    if (rd_addr2 != '0) op2 = (wb_en && rd_addr2 == wr_q) ? result_q : rf_q[rd_addr2];
  end

  assign alu_res = alu_f(op1, op2, imm, funct, shamt);

`ifdef RF_ALU_MUL_EN
  assign cmd_ready = (state_q != S_MUL);
  assign is_mul    = (funct == 4'b1100);
  assign acc_d     = mplier_q[0] ? acc_q + mcand_q : acc_q;
`else
  assign cmd_ready = 1'b1;
  assign is_mul    = 1'b0;
`endif

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_EXEC: begin
        if (!accept)     state_d = S_IDLE;
`ifdef RF_ALU_MUL_EN
        else if (is_mul) state_d = S_MUL;
`endif
        else             state_d = S_EXEC;
      end
`ifdef RF_ALU_MUL_EN
      S_MUL: if (cnt_q == CNT_W'(1)) state_d = S_EXEC;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      result_q   <= '0;
      wr_q       <= '0;
      we_q       <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) rf_q[i] <= '0;
`ifdef RF_ALU_MUL_EN
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (wb_en) rf_q[wr_q] <= result_q;
      if (accept) begin
        rd_data1_q <= op1;
        rd_data2_q <= op2;
        result_q   <= alu_res;
        wr_q       <= wr_addr;
        we_q       <= RegWrite;
`ifdef RF_ALU_MUL_EN
        mcand_q    <= op1;
        mplier_q   <= op2;
        acc_q      <= '0;
        cnt_q      <= CNT_W'(DATA_W);
`endif
      end
`ifdef RF_ALU_MUL_EN
      if (state_q == S_MUL) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) result_q <= acc_d;
      end
`endif
    end
  end

  assign rd_data1     = rd_data1_q;
  assign rd_data2     = rd_data2_q;
  assign result       = result_q;
  assign result_valid = (state_q == S_EXEC);
  assign dbg_data     = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_rf_alu_core.sv
// Scoreboard bench for rf_alu_core: accepted commands push expected results, a monitor checks each pulse.
module tb_rf_alu_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, dbg_addr = '0;
  logic        RegWrite = 1'b0;
  logic [4:0]  shamt = '0;
  logic [3:0]  funct = '0;
  logic [31:0] imm = '0;
  logic [31:0] rd_data1, rd_data2, result, dbg_data;
  logic        result_valid;

  typedef struct { logic [31:0] r; logic [31:0] a; logic [31:0] b; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_alu_core #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_addr(wr_addr), .RegWrite(RegWrite),
    .shamt(shamt), .funct(funct), .imm(imm), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .result(result), .result_valid(result_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_dbg(input int addr, input logic [31:0] exp);
    logic [31:0] a;
    a = addr;
    dbg_addr = a[4:0];
    #1;
    chk($sformatf("dbg_r%0d", addr), dbg_data, exp);
  endtask

  // Present a command, wait (bounded) for acceptance, then record its expected response.
  task automatic send(input logic [3:0] f, input int a1, input int a2, input int wa, input logic we,
                      input int sh, input logic [31:0] im,
                      input logic [31:0] er, input logic [31:0] e1, input logic [31:0] e2,
                      input bit expect_it);
    logic [31:0] t1, t2, tw, ts;
    int n;
    exp_t e;
    t1 = a1; t2 = a2; tw = wa; ts = sh;
    funct = f; rd_addr1 = t1[4:0]; rd_addr2 = t2[4:0]; wr_addr = tw[4:0];
    RegWrite = we; shamt = ts[4:0]; imm = im;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready %b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (expect_it) begin
      e.r = er; e.a = e1; e.b = e2;
      sb.push_back(e);
    end
    #1 cmd_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && result_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: result %h with empty scoreboard", result);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.r);
          chk("rd_data1", rd_data1, e.a);
          chk("rd_data2", rd_data2, e.b);
        end
      end
    end
  end

  initial begin : stim
    int low, idx;
    repeat (3) @(negedge clk);
    chk("reset_result_valid", {31'b0, result_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    for (int i = 0; i < 32; i++) chk_dbg(i, 32'd0);
    @(posedge clk); #1;

    // forwarding chain: r3 = r1 + r2 with r2 still in flight
    send(4'hB, 0, 0, 1, 1'b1, 0, 32'd7,        32'd7,        0, 0, 1'b1);
    send(4'hB, 0, 0, 2, 1'b1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b1);
    send(4'h0, 1, 2, 3, 1'b1, 0, 32'd0,        32'd6,        32'd7, 32'hFFFFFFFF, 1'b1);
    @(posedge clk); #1;
    chk_dbg(3, 32'd6);

    send(4'hB, 0, 0, 6, 1'b1, 0, 32'h80000000, 32'h80000000, 0, 0, 1'b1);
    send(4'hB, 0, 0, 7, 1'b1, 0, 32'd1,        32'd1,        0, 0, 1'b1);
    send(4'h8, 0, 6, 0, 1'b0, 4,  '0, 32'hF8000000, 0, 32'h80000000, 1'b1);
    send(4'h7, 0, 6, 0, 1'b0, 4,  '0, 32'h08000000, 0, 32'h80000000, 1'b1);
    send(4'h9, 2, 7, 0, 1'b0, 0,  '0, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b1);
    send(4'hA, 2, 7, 0, 1'b0, 0,  '0, 32'd0, 32'hFFFFFFFF, 32'd1, 1'b1);
    send(4'h1, 7, 1, 0, 1'b0, 0,  '0, 32'hFFFFFFFA, 32'd1, 32'd7, 1'b1);
    send(4'h2, 2, 1, 0, 1'b0, 0,  '0, 32'd7, 32'hFFFFFFFF, 32'd7, 1'b1);
    send(4'h3, 1, 7, 0, 1'b0, 0,  '0, 32'd7, 32'd7, 32'd1, 1'b1);
    send(4'h4, 1, 2, 0, 1'b0, 0,  '0, 32'hFFFFFFF8, 32'd7, 32'hFFFFFFFF, 1'b1);
    send(4'h5, 1, 7, 0, 1'b0, 0,  '0, 32'hFFFFFFF8, 32'd7, 32'd1, 1'b1);
    send(4'h6, 0, 7, 0, 1'b0, 31, '0, 32'h80000000, 0, 32'd1, 1'b1);
    send(4'hF, 1, 2, 0, 1'b0, 0,  '0, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1);

    // writes to r0 are shown but dropped, and r0 never forwards
    send(4'hB, 0, 0, 0, 1'b1, 0, 32'd5, 32'd5, 0, 0, 1'b1);
    send(4'h0, 0, 0, 4, 1'b1, 0, '0,    32'd0, 0, 0, 1'b1);
    @(posedge clk); #1;
    chk_dbg(0, 32'd0);
    chk_dbg(4, 32'd0);

    send(4'hB, 0, 0, 13, 1'b1, 0, 32'd6, 32'd6, 0, 0, 1'b1);
`ifdef RF_ALU_MUL_EN
    send(4'hC, 1, 13, 14, 1'b1, 0, '0, 32'd42, 32'd7, 32'd6, 1'b1);
`else
    send(4'hC, 1, 13, 14, 1'b1, 0, '0, 32'd0, 32'd7, 32'd6, 1'b1);
`endif
    low = 0; idx = 0;
    @(negedge clk);
    while (!result_valid && idx < 100) begin
      if (!cmd_ready) low++;
      idx++;
      @(negedge clk);
    end
`ifdef RF_ALU_MUL_EN
    chk("mul_ready_low_cycles", low, 32'd32);
    chk("mul_latency", idx, 32'd32);
`else
    chk("mul_ready_low_cycles", low, 32'd0);
    chk("mul_latency", idx, 32'd0);
`endif
    @(posedge clk); #1;
`ifdef RF_ALU_MUL_EN
    chk_dbg(14, 32'd42);
`else
    chk_dbg(14, 32'd0);
`endif

    // reset in the middle of a multiply: nothing may complete or be written
`ifdef RF_ALU_MUL_EN
    send(4'hC, 1, 13, 5, 1'b1, 0, '0, 32'd0, 32'd7, 32'd6, 1'b0);
`else
    send(4'hC, 1, 13, 5, 1'b1, 0, '0, 32'd0, 32'd7, 32'd6, 1'b1);
`endif
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_result_valid", {31'b0, result_valid}, 32'd0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk_dbg(5, 32'd0);
    chk_dbg(1, 32'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk_dbg(5, 32'd0);

    send(4'hB, 0, 0, 1, 1'b1, 0, 32'h12, 32'h12, 0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk_dbg(1, 32'h12);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
